run_controller: RTL and testbench
=================================

# run_controller

Synthesizable run-sequencing controller for the 64-bit single-cycle processor. It holds the core in reset for a parameterised number of cycles, then lets it run. The run ends on a halt request or a programmable cycle limit. The controller then drives an ordered, handshaked state-dump sweep over `NUM_CH` storage channels (register file, data memory, ...). It sits between the board or bench control inputs and the `processor_arm` reset/dump pins, and replaces fixed-delay reset/dump sequencing with a counted, restartable one.

## Interface
Parameters:
- `CNT_W`, 32, width of cycle counter and run limit
- `RST_CYCLES`, 2, cycles `core_reset` stays high after a start (≥1)
- `NUM_CH`, 2, number of dump channels (≥1)
- `DEPTH`, 32, entries swept per channel (≥2)
- `CH_W`, max(1,$clog2(NUM_CH)), derived
- `ADDR_W`, $clog2(DEPTH), derived

Ports:
- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `start`  in  1  single-cycle request to begin a run
- `run_limit`  in  CNT_W  max RUN cycles; 0 = unlimited; sampled on accepted `start`
- `halt`  in  1  core end-of-program indication
- `core_reset`  out  1  active-high reset to processor
- `core_en`  out  1  high only in RUN
- `dump`  out  1  high throughout DUMP (drives processor `dump`)
- `dump_valid`  out  1  current dump beat valid
- `dump_ready`  in  1  consumer accepts beat
- `dump_ch`  out  CH_W  channel of current beat
- `dump_addr`  out  ADDR_W  entry of current beat
- `cycle_count`  out  CNT_W  RUN cycles elapsed in current/last run
- `busy`  out  1  high in RESET, RUN, DUMP
- `done`  out  1  high in DONE
- `timeout`  out  1  last run ended by `run_limit`, not `halt`

## Operation
- States: IDLE, RESET, RUN, DUMP, DONE.
- `reset`=0 at any edge → IDLE. Clears the counter, `dump_ch`, `dump_addr`, `timeout` and the latched limit. This applies mid-run and mid-dump; no partial dump completes.
- Output values in IDLE/after reset: `core_reset`=1, `core_en`=0, `dump`=0, `dump_valid`=0, `dump_ch`=0, `dump_addr`=0, `cycle_count`=0, `busy`=0, `done`=0, `timeout`=0.
- IDLE or DONE with `start`=1 → RESET. This latches `run_limit`, clears `cycle_count`/`timeout`, and loads the reset counter.
- `start` is ignored in RESET, RUN and DUMP.
- RESET: `core_reset`=1 for exactly `RST_CYCLES` cycles → RUN.
- RUN: `core_reset`=0, `core_en`=1, and `cycle_count` increments every cycle.
  - With an unlimited limit, `cycle_count` saturates at all-ones and does not wrap.
- RUN exit is evaluated each cycle, after that cycle's increment is taken:
  - `halt`=1 → DUMP, `timeout`=0.
  - Else if limit≠0 and `cycle_count`==limit−1 → DUMP, `timeout`=1; `cycle_count` ends at limit.
  - `halt` and limit reached in the same cycle → `halt` wins, `timeout`=0.
- DUMP: `core_reset`=0, `core_en`=0, `dump`=1, `dump_valid`=1.
  - Beat order: `dump_ch` is the outer loop (0..NUM_CH−1), `dump_addr` the inner loop (0..DEPTH−1).
  - A beat advances only on `dump_valid`&`dump_ready`. `dump_ch`/`dump_addr` stay stable while `dump_ready`=0.
  - `dump_addr` wraps DEPTH−1→0 while `dump_ch` increments.
  - Handshake on the final beat (NUM_CH−1, DEPTH−1) → DONE.
- DONE: `done`=1, `core_reset`=1, `dump`=0, `dump_valid`=0. `cycle_count` and `timeout` are held until the next start.

## Timing
- `start` at edge k → `busy`=1 from k+1. RUN begins at edge k+1+`RST_CYCLES`.
- The first RUN cycle shows `cycle_count`=0 before the edge and 1 after.
- `halt` sampled at edge m in RUN → `dump`=1 from m+1 (one cycle latency). The core is frozen from m+1.
- DUMP length = NUM_CH·DEPTH handshakes. The minimum is NUM_CH·DEPTH cycles with `dump_ready` tied high.
- `done` rises the cycle after the last handshake.
- All outputs are registered or decoded from registered state only. There is no combinational path from `dump_ready`, `halt` or `start` to any output.

## Test plan
- Reset hold: `reset`=0 for 3 cycles, `start`=1 pulsed during them → stays IDLE, all outputs at reset values, `core_reset`=1.
- Halt run: `RST_CYCLES`=2, `run_limit`=0, `start` pulse, `halt` at the 10th RUN cycle → `core_reset` high 2 cycles, `cycle_count`=10, `timeout`=0, `dump` next cycle.
- Limit run: `run_limit`=310, `halt`=0 → exactly 310 RUN cycles, `cycle_count`=310, `timeout`=1. A repeat with `halt` on cycle 310 → `timeout`=0.
- Dump sweep: NUM_CH=2, DEPTH=32, `dump_ready` toggled 1/0 → 64 beats in order (0,0)…(0,31),(1,0)…(1,31), addresses held while not ready, `done` after beat 64.
- Mid-dump reset: `reset`=0 at beat 20 → IDLE next edge, `dump`=0, `dump_addr`=0. A new `start` yields a full 64-beat dump.
- Restart from DONE: `start` in DONE with `run_limit`=5 → `done`=0, `cycle_count` cleared, run ends with `cycle_count`=5, `timeout`=1.

Source files
------------

// File: rtl/run_controller.sv
// Run-sequencing controller: holds the core in reset, lets it run until halt or a cycle limit,
// then walks a handshaked state dump over every storage channel.
module run_controller #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  run_limit,
   input  logic              halt,
   output logic              core_reset,
   output logic              core_en,
   output logic              dump,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [CH_W-1:0]   dump_ch,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {StIdle, StReset, StRun, StDump, StDone} state_e;

   state_e            state_q, state_d;
   logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0]  limit_q, limit_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic              timeout_q, timeout_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q   <= StIdle;
         rst_cnt_q <= '0;
         limit_q   <= '0;
         cycle_q   <= '0;
         timeout_q <= 1'b0;
         ch_q      <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         limit_q   <= limit_d;
         cycle_q   <= cycle_d;
         timeout_q <= timeout_d;
         ch_q      <= ch_d;
         addr_q    <= addr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      limit_d   = limit_q;
      cycle_d   = cycle_q;
      timeout_d = timeout_q;
      ch_d      = ch_q;
      addr_d    = addr_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StReset;
               limit_d   = run_limit;
               cycle_d   = '0;
               timeout_d = 1'b0;
               rst_cnt_d = RstW'(RST_CYCLES - 1);
            end
         end
         StReset: begin
            if (rst_cnt_q == '0) begin
               state_d = StRun;
            end else begin
               rst_cnt_d = rst_cnt_q - RstW'(1);
            end
         end
         StRun: begin
            // Saturate rather than wrap on unlimited runs.
            if (cycle_q != '1) begin
               cycle_d = cycle_q + CNT_W'(1);
            end
            if (halt) begin
               state_d   = StDump;
               timeout_d = 1'b0;
            end else if (limit_q != '0 && cycle_q == limit_q - CNT_W'(1)) begin
               state_d   = StDump;
               timeout_d = 1'b1;
            end
         end
         StDump: begin
            if (dump_ready) begin
               if (addr_q == ADDR_W'(DEPTH - 1)) begin
                  addr_d = '0;
                  if (ch_q == CH_W'(NUM_CH - 1)) begin
                     ch_d    = '0;
                     state_d = StDone;
                  end else begin
                     ch_d = ch_q + CH_W'(1);
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign core_reset  = (state_q == StIdle) || (state_q == StReset) || (state_q == StDone);
   assign core_en     = (state_q == StRun);
   assign dump        = (state_q == StDump);
   assign dump_valid  = (state_q == StDump);
   assign busy        = (state_q == StReset) || (state_q == StRun) || (state_q == StDump);
   assign done        = (state_q == StDone);
   assign dump_ch     = ch_q;
   assign dump_addr   = addr_q;
   assign cycle_count = cycle_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: reset hold, halt/limit runs, dump sweep, mid-dump reset,
// restart from DONE.
module tb_run_controller;

   localparam int CNT_W  = 32;
   localparam int NUM_CH = 2;
   localparam int DEPTH  = 32;
   localparam int CH_W   = 1;
   localparam int ADDR_W = 5;
   localparam int NBEAT  = NUM_CH * DEPTH;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic              start;
   logic [CNT_W-1:0]  run_limit;
   logic              halt;
   logic              core_reset, core_en, dump, dump_valid, dump_ready;
   logic [CH_W-1:0]   dump_ch;
   logic [ADDR_W-1:0] dump_addr;
   logic [CNT_W-1:0]  cycle_count;
   logic              busy, done, timeout;

   int vectors = 0;
   int miscompares = 0;

   run_controller #(
      .CNT_W(CNT_W), .RST_CYCLES(2), .NUM_CH(NUM_CH), .DEPTH(DEPTH)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .run_limit(run_limit), .halt(halt),
      .core_reset(core_reset), .core_en(core_en), .dump(dump), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_ch(dump_ch), .dump_addr(dump_addr),
      .cycle_count(cycle_count), .busy(busy), .done(done), .timeout(timeout)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(negedge CLOCK_50);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_vec"},
            {core_reset, core_en, dump, dump_valid, busy, done, timeout},
            64'b1000000);
      check({tag, "_pos"}, {dump_ch, dump_addr}, 64'd0);
      check({tag, "_cnt"}, cycle_count, 64'd0);
   endtask

   // Pulse start, then count the cycles spent with core_reset held before RUN.
   task automatic start_run(input logic [CNT_W-1:0] lim, output int rst_len);
      run_limit = lim;
      start = 1'b1;
      tick();
      start = 1'b0;
      rst_len = 0;
      while (!core_en && rst_len < 20) begin
         if (!core_reset) rst_len = 100;
         rst_len++;
         tick();
      end
   endtask

   task automatic run_to_dump(output int n);
      n = 0;
      while (core_en && n < 2000) begin
         n++;
         tick();
      end
   endtask

   task automatic sweep(input bit toggle, input string tag);
      int b = 0;
      int cyc = 0;
      bit rdy = 1'b1;
      while (b < NBEAT && cyc < 1000) begin
         check({tag, "_beat"}, {dump_valid, dump, dump_ch, dump_addr},
               64'(3 * 64 + (b / DEPTH) * 32 + (b % DEPTH)));
         dump_ready = rdy;
         tick();
         if (rdy) b++;
         cyc++;
         if (toggle) rdy = !rdy;
      end
      dump_ready = 1'b0;
      check({tag, "_cycles"}, 64'(cyc), toggle ? 64'(2 * NBEAT - 1) : 64'(NBEAT));
      check({tag, "_done"}, {done, dump, dump_valid, core_reset, busy}, 64'b10010);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      start = 1'b0;
      run_limit = '0;
      halt = 1'b0;
      dump_ready = 1'b0;

      // Reset hold with start pulsed.
      start = 1'b1;
      repeat (3) tick();
      check_idle("reset_hold");
      reset = 1'b1;
      start = 1'b0;
      tick();
      check_idle("idle_after_reset");

      // Halt run: halt asserted in the 10th RUN cycle.
      start_run(32'd0, n);
      check("halt_rst_len", 64'(n), 64'd2);
      check("run_first_cnt", cycle_count, 64'd0);
      repeat (9) tick();
      check("run_cnt9", {core_en, core_reset, cycle_count}, {2'b10, 32'd9});
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_dump", {dump, core_en, core_reset, timeout}, 64'b1000);
      check("halt_cnt", cycle_count, 64'd10);

      // Dump sweep with ready toggling.
      sweep(1'b1, "sweep_toggle");
      check("done_hold", {timeout, cycle_count}, 64'd10);

      // Limit run from DONE; start mid-run must be ignored.
      start_run(32'd310, n);
      check("lim_rst_len", 64'(n), 64'd2);
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to_dump(n);
      check("lim_run_len", 64'(n + 6), 64'd310);
      check("lim_cnt", cycle_count, 64'd310);
      check("lim_timeout", {dump, timeout}, 64'b11);
      sweep(1'b0, "sweep_full");

      // Halt coincides with the limit: halt wins.
      start_run(32'd310, n);
      repeat (309) tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("tie_cnt", cycle_count, 64'd310);
      check("tie_timeout", {dump, timeout}, 64'b10);
      sweep(1'b0, "sweep_tie");

      // Reset in the middle of a dump.
      start_run(32'd3, n);
      run_to_dump(n);
      check("mid_run_len", 64'(n), 64'd3);
      dump_ready = 1'b1;
      repeat (20) tick();
      check("mid_beat20", {dump, dump_ch, dump_addr}, 64'(64 + 20));
      dump_ready = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_idle("mid_reset");
      start_run(32'd4, n);
      run_to_dump(n);
      check("mid_rerun_len", {timeout, cycle_count}, {1'b1, 32'd4});
      sweep(1'b0, "sweep_after_reset");

      // Restart from DONE with a short limit.
      run_limit = 32'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_clear", {done, busy, timeout, cycle_count}, 64'b010 << 32);
      n = 0;
      while (!dump && n < 50) begin
         n++;
         tick();
      end
      check("restart_cnt", {dump, timeout, cycle_count}, {2'b11, 32'd5});
      check("restart_len", 64'(n), 64'd7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
